// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: tap table, checker state encoding and width helpers.
// The generator and the checker both call lfsr_fb so the tap table exists once.
package lfsr_pkg;

  localparam int unsigned MaxBits = 64;

  typedef enum logic {
    SEARCH,
    LOCKED
  } lfsr_state_e;

  // True for the widths that have an entry in the tap table.
  function automatic bit lfsr_width_ok(int unsigned width);
    return ((width >= 3) && (width <= 32)) || (width == 64);
  endfunction

  // All-ones word of the given width; this is the XNOR lock-up value.
  function automatic logic [MaxBits-1:0] lfsr_all_ones(int unsigned width);
    logic [MaxBits-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxBits; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // XNOR feedback over the 1-indexed taps, evaluated left to right.
  // Tap t of the table reads s[t-1]. Unsupported widths feed back a constant 1.
  function automatic logic lfsr_fb(int unsigned width, logic [MaxBits-1:0] s);
    logic fb;
    case (width)
      3:       fb = s[2] ~^ s[1];
      4:       fb = s[3] ~^ s[2];
      5:       fb = s[4] ~^ s[2];
      6:       fb = s[5] ~^ s[4];
      7:       fb = s[6] ~^ s[5];
      8:       fb = s[7] ~^ s[5] ~^ s[4] ~^ s[3];
      9:       fb = s[8] ~^ s[4];
      10:      fb = s[9] ~^ s[6];
      11:      fb = s[10] ~^ s[8];
      12:      fb = s[11] ~^ s[5] ~^ s[3] ~^ s[0];
      13:      fb = s[12] ~^ s[3] ~^ s[2] ~^ s[0];
      14:      fb = s[13] ~^ s[4] ~^ s[2] ~^ s[0];
      15:      fb = s[14] ~^ s[13];
      16:      fb = s[15] ~^ s[14] ~^ s[12] ~^ s[3];
      17:      fb = s[16] ~^ s[13];
      18:      fb = s[17] ~^ s[10];
      19:      fb = s[18] ~^ s[5] ~^ s[1] ~^ s[0];
      20:      fb = s[19] ~^ s[16];
      21:      fb = s[20] ~^ s[18];
      22:      fb = s[21] ~^ s[20];
      23:      fb = s[22] ~^ s[17];
      24:      fb = s[23] ~^ s[22] ~^ s[21] ~^ s[16];
      25:      fb = s[24] ~^ s[21];
      26:      fb = s[25] ~^ s[5] ~^ s[1] ~^ s[0];
      27:      fb = s[26] ~^ s[4] ~^ s[1] ~^ s[0];
      28:      fb = s[27] ~^ s[24];
      29:      fb = s[28] ~^ s[26];
      30:      fb = s[29] ~^ s[5] ~^ s[3] ~^ s[0];
      31:      fb = s[30] ~^ s[27];
      32:      fb = s[31] ~^ s[21] ~^ s[1] ~^ s[0];
      64:      fb = s[63] ~^ s[62] ~^ s[60] ~^ s[59];
      default: fb = 1'b1;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream and status bundle between an LFSR source and the checker.
interface lfsr_checker_if #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned ERR_BITS = 16
);

  logic                enable;
  logic [NUM_BITS-1:0] i_Data;
  logic                i_Clear_Errors;
  logic                o_Locked;
  logic                o_Error;
  logic [ERR_BITS-1:0] o_Error_Count;

  modport master (
    output enable,
    output i_Data,
    output i_Clear_Errors,
    input  o_Locked,
    input  o_Error,
    input  o_Error_Count
  );

  modport slave (
    input  enable,
    input  i_Data,
    input  i_Clear_Errors,
    output o_Locked,
    output o_Error,
    output o_Error_Count
  );

endinterface

// File: rtl/lfsr_next.sv
// Combinational next-word unit: shifts left and inserts the XNOR feedback bit.
module lfsr_next #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0] cur,
  output logic [NUM_BITS-1:0] nxt
);

  import lfsr_pkg::*;

  logic [MaxBits-1:0] cur_ext;
  logic               fb;

  // Zero-extend so the shared tap function can take any supported width.
  always_comb begin
    cur_ext                = '0;
    cur_ext[NUM_BITS-1:0]  = cur;
    fb                     = lfsr_fb(NUM_BITS, cur_ext);
    nxt                    = {cur[NUM_BITS-2:0], fb};
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker. Searches for the sequence by reseeding from every
// received word, locks after LOCK_COUNT consecutive correct predictions, then
// free-runs its own prediction and counts mismatches until LOSS_COUNT in a row.
module lfsr_checker #(
  parameter int unsigned NUM_BITS   = 32,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 8,
  parameter int unsigned ERR_BITS   = 16
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave bus
);

  import lfsr_pkg::*;

  localparam int unsigned         CntBits   = 8;
  localparam logic [CntBits-1:0]  LockLimit = CntBits'(LOCK_COUNT);
  localparam logic [CntBits-1:0]  LossLimit = CntBits'(LOSS_COUNT);
  localparam logic [NUM_BITS-1:0] AllOnes   = NUM_BITS'(lfsr_all_ones(NUM_BITS));

  lfsr_state_e         state_q, state_d;
  logic [NUM_BITS-1:0] pred_q, pred_d;
  logic                seeded_q, seeded_d;
  logic [CntBits-1:0]  match_cnt_q, match_cnt_d;
  logic [CntBits-1:0]  miss_cnt_q, miss_cnt_d;
  logic                err_q, err_d;
  logic [ERR_BITS-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_BITS-1:0] rx_nxt;
  logic [NUM_BITS-1:0] pred_nxt;
  logic                hit;

  // Successor of the received word, used to reseed while searching.
  lfsr_next #(
    .NUM_BITS (NUM_BITS)
  ) u_next_rx (
    .cur (bus.i_Data),
    .nxt (rx_nxt)
  );

  // Successor of the current prediction, used to free-run while locked.
  lfsr_next #(
    .NUM_BITS (NUM_BITS)
  ) u_next_pred (
    .cur (pred_q),
    .nxt (pred_nxt)
  );

  // Next-state logic; clear is applied before the new error so both together give 1.
  // The clear acts on any cycle, independent of enable.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    seeded_d    = seeded_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = bus.i_Clear_Errors ? '0 : err_cnt_q;
    hit         = (bus.i_Data == pred_q);

    if (bus.enable) begin
      unique case (state_q)
        SEARCH: begin
          pred_d   = rx_nxt;
          seeded_d = 1'b1;
          // The first word only seeds; all-ones is the lock-up word and never counts.
          if (seeded_q && hit && (bus.i_Data != AllOnes)) begin
            match_cnt_d = match_cnt_q + CntBits'(1);
            if (match_cnt_d == LockLimit) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          pred_d = pred_nxt;
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_BITS'(1);
            miss_cnt_d = miss_cnt_q + CntBits'(1);
            if (miss_cnt_d == LossLimit) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
              pred_d      = rx_nxt;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      seeded_q    <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      seeded_q    <= seeded_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.o_Locked      = (state_q == LOCKED);
  assign bus.o_Error       = err_q;
  assign bus.o_Error_Count = err_cnt_q;

  // Unsupported widths fall back to a constant feedback of 1.
  a_width_ok : assert property (@(posedge clk) lfsr_width_ok(NUM_BITS))
    else $error("lfsr_checker: unsupported NUM_BITS=%0d", NUM_BITS);

endmodule
